// File: rtl/shot_pool_scheduler_if.sv
// shot_pool_scheduler_if: fire/kill controls, shared pool read port and pool status
interface shot_pool_scheduler_if #(parameter int SLOTS = 8);
    localparam int IW = $clog2(SLOTS);
    localparam int CW = $clog2(SLOTS + 1);
    logic                fire;
    logic [9:0]          pos_x;
    logic                kill_valid;
    logic [IW-1:0]       kill_slot;
    logic                draw_req;
    logic [IW-1:0]       draw_slot;
    logic                hit_req;
    logic [IW-1:0]       hit_slot;
    logic                draw_gnt;
    logic                hit_gnt;
    logic                rd_valid;
    logic                rd_owner;
    logic                rd_active;
    logic [9:0]          rd_x;
    logic signed [9:0]   rd_y;
    logic [SLOTS-1:0]    active_mask;
    logic [CW-1:0]       active_count;
    logic                fire_drop;
    modport master (
        output fire, pos_x, kill_valid, kill_slot, draw_req, draw_slot, hit_req, hit_slot,
        input  draw_gnt, hit_gnt, rd_valid, rd_owner, rd_active, rd_x, rd_y,
               active_mask, active_count, fire_drop
    );
    modport slave (
        input  fire, pos_x, kill_valid, kill_slot, draw_req, draw_slot, hit_req, hit_slot,
        output draw_gnt, hit_gnt, rd_valid, rd_owner, rd_active, rd_x, rd_y,
               active_mask, active_count, fire_drop
    );
endinterface

// File: rtl/shot_pool_scheduler.sv
// shot_pool_scheduler: bullet pool owner with spawn, tick walk, kill and read arbitration
module shot_pool_scheduler #(
    parameter int                 SLOTS    = 8,
    parameter int                 TICK_DIV = 60000,
    parameter logic signed [9:0]  SPAWN_Y  = 10'sd424,
    parameter logic signed [9:0]  KILL_Y   = -10'sd10,
    parameter logic signed [9:0]  Y_STEP   = 10'sd1
) (
    input logic                    clk,
    input logic                    reset,
    shot_pool_scheduler_if.slave   bus
);
    localparam int IW = $clog2(SLOTS);
    localparam int CW = $clog2(SLOTS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, STEP} state_t;

    state_t            state;
    logic [SLOTS-1:0]  valid;
    logic [9:0]        x_mem [SLOTS];
    logic signed [9:0] y_mem [SLOTS];
    logic [IW-1:0]     idx;
    logic [TW-1:0]     cnt;
    logic              tick_pending;
    logic              spawn_pending;
    logic              fire_q;
    logic              last_hit;
    logic [IW-1:0]     free_idx;
    logic              any_free;
    logic [CW-1:0]     pop;
    logic [IW-1:0]     sel;
    logic              wrap;
    logic              do_spawn;
    logic              take_tick;
    logic              kill_hit;

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        pop      = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IW'(i);
                any_free = 1'b1;
            end
            pop = pop + CW'(valid[i]);
        end
    end

    assign wrap         = cnt == TW'(TICK_DIV - 1);
    assign do_spawn     = state == IDLE && spawn_pending;
    assign take_tick    = state == IDLE && !spawn_pending && tick_pending;
    // kill of a free slot must not collide with a spawn into that same slot
    assign kill_hit     = bus.kill_valid && valid[bus.kill_slot];
    assign bus.draw_gnt = bus.draw_req && (!bus.hit_req || last_hit);
    assign bus.hit_gnt  = bus.hit_req && (!bus.draw_req || !last_hit);
    assign sel          = bus.hit_gnt ? bus.hit_slot : bus.draw_slot;
    assign bus.active_mask = valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            valid            <= '0;
            idx              <= '0;
            cnt              <= '0;
            tick_pending     <= 1'b0;
            spawn_pending    <= 1'b0;
            fire_q           <= 1'b0;
            last_hit         <= 1'b1;
            bus.rd_valid     <= 1'b0;
            bus.rd_owner     <= 1'b0;
            bus.rd_active    <= 1'b0;
            bus.rd_x         <= '0;
            bus.rd_y         <= '0;
            bus.active_count <= '0;
            bus.fire_drop    <= 1'b0;
        end else begin
            fire_q           <= bus.fire;
            cnt              <= wrap ? '0 : cnt + 1'b1;
            tick_pending     <= wrap || (tick_pending && !take_tick);
            spawn_pending    <= (fire_q && !bus.fire) || (spawn_pending && !do_spawn);
            bus.fire_drop    <= do_spawn && !any_free;
            bus.active_count <= pop;
            bus.rd_valid     <= bus.draw_gnt || bus.hit_gnt;
            if (bus.draw_gnt || bus.hit_gnt) begin
                last_hit      <= bus.hit_gnt;
                bus.rd_owner  <= bus.hit_gnt;
                bus.rd_active <= valid[sel];
                bus.rd_x      <= x_mem[sel];
                bus.rd_y      <= y_mem[sel];
            end
            if (do_spawn && any_free) begin
                valid[free_idx] <= 1'b1;
                x_mem[free_idx] <= bus.pos_x;
                y_mem[free_idx] <= SPAWN_Y;
            end
            if (state == STEP && valid[idx] && !(kill_hit && bus.kill_slot == idx)) begin
                if (y_mem[idx] < KILL_Y) valid[idx] <= 1'b0;
                else y_mem[idx] <= y_mem[idx] - Y_STEP;
            end
            if (kill_hit) valid[bus.kill_slot] <= 1'b0;
            if (state == IDLE) begin
                if (take_tick) begin
                    state <= STEP;
                    idx   <= '0;
                end
            end else begin
                idx <= idx + 1'b1;
                if (idx == IW'(SLOTS - 1)) state <= IDLE;
            end
        end
    end
endmodule
